spi_target: RTL and testbench



---
 rtl/spi_target_pkg.sv | 15 +
 rtl/spi_target_if.sv | 29 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_target.sv | 163 ++++++++++++++++
 tb/tb_spi_target.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_pkg.sv
// spi_target shared types and constants.
// No ports: state encoding, command bit position, MISO idle byte.
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } state_t;

  localparam int CMD_RW_BIT = 7;
  localparam logic [7:0] MISO_IDLE = 8'h00;

endpackage

// File: rtl/spi_target_if.sv
// Register bus between spi_target (master) and the register file (slave).
// reg_addr/reg_wr/reg_wdata/reg_rd out of master; reg_rdata back 1 cycle after reg_rd.
interface spi_target_if #(
  parameter int ADDR_W = 7
);

  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [7:0]        reg_wdata;
  logic              reg_rd;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr,
    output reg_wr,
    output reg_wdata,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wr,
    input  reg_wdata,
    input  reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Input synchronizer plus registered rise/fall detect for one async pin.
// Ports: clk, reset, din in; sync (level), rise, fall out, all aligned.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT      = 1'b0,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   tip;

  assign tip = chain[SYNC_STAGES-1];

  // sync is the edge-detect register itself, so level and edge
  // pulses describe the same sample of the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      sync  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din ^ INVERT};
      sync  <= tip;
      rise  <= tip & ~sync;
      fall  <= ~tip & sync;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 responder giving the host byte access to a register space.
// Ports: clk_48mhz, reset, spi_sck/cs/mosi in, spi_miso/oe out, bus (master).
module spi_target
  import spi_target_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  input  logic            spi_sck,
  input  logic            spi_cs,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  spi_target_if.master    bus
);

  logic sck_rise, sck_fall, sck_unused_lvl;
  logic cs_act, cs_start, cs_unused_stop;
  logic mosi_s, mosi_unused_r, mosi_unused_f;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .INVERT(1'b0),
    .RST_VAL(1'b0)
  ) u_sck (
    .clk(clk_48mhz),
    .reset(reset),
    .din(spi_sck),
    .sync(sck_unused_lvl),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  // CS is inverted so cs_act is high inside a frame. It resets to
  // active: a frame already running keeps us in HOLD until it ends.
  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .INVERT(1'b1),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk(clk_48mhz),
    .reset(reset),
    .din(spi_cs),
    .sync(cs_act),
    .rise(cs_start),
    .fall(cs_unused_stop)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .INVERT(1'b0),
    .RST_VAL(1'b0)
  ) u_mosi (
    .clk(clk_48mhz),
    .reset(reset),
    .din(spi_mosi),
    .sync(mosi_s),
    .rise(mosi_unused_r),
    .fall(mosi_unused_f)
  );

  state_t            state_q, state_d;
  logic [2:0]        bit_q;
  logic [6:0]        rx_q;
  logic [7:0]        tx_q;
  logic [7:0]        rx_byte;
  logic              rd_dir_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q, rd_q;
  logic [7:0]        wdata_q;
  logic              miso_q, oe_q;
  logic              byte_done;
  logic              in_frame;

  assign rx_byte  = {rx_q, mosi_s};
  assign in_frame = cs_act &&
                    (state_q == ST_CMD || state_q == ST_DATA);

  always_ff @(posedge clk_48mhz) begin
    if (reset) state_q <= ST_HOLD;
    else       state_q <= state_d;
  end

  // CS inactive beats everything, including a same-cycle SCK rise.
  always_comb begin
    state_d   = state_q;
    byte_done = sck_rise && (bit_q == 3'd7);
    unique case (1'b1)
      !cs_act:
        state_d = ST_IDLE;
      cs_act && state_q == ST_IDLE && cs_start:
        state_d = ST_CMD;
      cs_act && state_q == ST_CMD && byte_done:
        state_d = ST_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      bit_q     <= '0;
      rx_q      <= '0;
      tx_q      <= MISO_IDLE;
      rd_dir_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_pend_q <= rd_q;
      oe_q      <= (state_d == ST_CMD) ||
                   (state_d == ST_DATA);
      if (wr_q) addr_q <= addr_q + ADDR_W'(1);
      if (!in_frame) begin
        bit_q  <= '0;
        rx_q   <= '0;
        tx_q   <= MISO_IDLE;
        miso_q <= MISO_IDLE[7];
      end else begin
        if (sck_rise) begin
          bit_q <= bit_q + 3'd1;
          rx_q  <= rx_byte[6:0];
          if (byte_done) begin
            if (state_q == ST_CMD) begin
              addr_q   <= rx_byte[ADDR_W-1:0];
              rd_dir_q <= rx_byte[CMD_RW_BIT];
              rd_q     <= rx_byte[CMD_RW_BIT];
            end else if (rd_dir_q) begin
              // prefetch the byte that goes out next
              addr_q <= addr_q + ADDR_W'(1);
              rd_q   <= 1'b1;
            end else begin
              wr_q    <= 1'b1;
              wdata_q <= rx_byte;
            end
          end
        end
        // tx_q holds zeros except after a read prefetch
        if (sck_fall) begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
        if (rd_pend_q) tx_q <= bus.reg_rdata;
      end
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_rd    = rd_q;
  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: host-side SPI driver, register file on the bus,
// frame-level reference model and a strobe monitor.
module tb_spi_target;

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk_48mhz = 1'b0;
  logic reset     = 1'b1;
  logic spi_sck   = 1'b0;
  logic spi_cs    = 1'b1;
  logic spi_mosi  = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;

  spi_target_if #(.ADDR_W(7)) bus ();

  spi_target #(
    .ADDR_W(7),
    .SYNC_STAGES(2)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset(reset),
    .spi_sck(spi_sck),
    .spi_cs(spi_cs),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .bus(bus)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  // Register file: rdata is only meaningful the cycle after reg_rd.
  logic [7:0] smem [128];
  always @(posedge clk_48mhz) begin
    if (reset) begin
      for (int i = 0; i < 128; i++)
        smem[i] <= 8'(i) ^ 8'hFF;
      bus.reg_rdata <= 8'h00;
    end else begin
      if (bus.reg_wr) smem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_rd) bus.reg_rdata <= smem[bus.reg_addr];
      else            bus.reg_rdata <= 8'($urandom);
    end
  end

  int         vectors    = 0;
  int         miscompares = 0;
  int         half       = 6;
  logic [7:0] ref_mem [128];
  logic [7:0] wbuf [128];
  logic [7:0] rxb [129];
  ev_t        exp_q [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    #(half * 20);
    spi_sck = 1'b1;
    m = spi_miso;
    #(half * 20);
    spi_sck = 1'b0;
  endtask

  task automatic cs_low();
    @(posedge clk_48mhz);
    #($urandom_range(1, 19));
    spi_cs = 1'b0;
    #(20 * $urandom_range(2, 8));
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int n);
    logic [6:0] a;
    logic [7:0] r, emiso, tx;
    logic       m;
    ev_t        e;
    a = cmd[6:0];
    for (int k = 0; k <= n; k++) begin
      e.addr = a + 7'(k);
      if (cmd[7]) begin
        e.wr = 1'b0; e.data = 8'h00; exp_q.push_back(e);
      end else if (k < n) begin
        e.wr = 1'b1; e.data = wbuf[k]; exp_q.push_back(e);
      end
    end
    cs_low();
    r = 8'h00;
    for (int i = 0; i <= n; i++) begin
      emiso = (cmd[7] && i > 0) ? ref_mem[a + 7'(i - 1)] : 8'h00;
      if (i == 0)      tx = cmd;
      else if (!cmd[7]) tx = wbuf[i - 1];
      else              tx = 8'($urandom);
      for (int j = 7; j >= 0; j--) begin
        spi_bit(tx[j], m);
        r = {r[6:0], m};
      end
      rxb[i] = r;
      chk("miso_byte", 32'(r), 32'(emiso));
      if (!cmd[7] && i > 0) ref_mem[a + 7'(i - 1)] = tx;
    end
    #(20 * $urandom_range(1, 4));
    chk("oe_in_frame", 32'(spi_miso_oe), 32'd1);
    spi_cs = 1'b1;
    repeat (8) @(posedge clk_48mhz);
    #1;
    chk("oe_after_frame", 32'(spi_miso_oe), 32'd0);
    chk("miso_after_frame", 32'(spi_miso), 32'd0);
    chk("events_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] c;
    logic       m;
    int         n;

    fork
      begin : monitor
        ev_t e;
        forever begin
          @(negedge clk_48mhz);
          if (!reset && (bus.reg_wr || bus.reg_rd)) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_strobe",
                  32'({bus.reg_wr, bus.reg_rd}), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("strobe_is_wr", 32'(bus.reg_wr), 32'(e.wr));
              chk("strobe_is_rd", 32'(bus.reg_rd), 32'(!e.wr));
              chk("strobe_addr", 32'(bus.reg_addr), 32'(e.addr));
              if (e.wr)
                chk("strobe_wdata", 32'(bus.reg_wdata), 32'(e.data));
            end
          end
        end
      end
    join_none

    model_reset();
    repeat (4) @(posedge clk_48mhz);
    #1;
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_wr", 32'(bus.reg_wr), 32'd0);
    chk("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    chk("rst_rd", 32'(bus.reg_rd), 32'd0);
    @(negedge clk_48mhz);
    reset = 1'b0;
    repeat (8) @(posedge clk_48mhz);

    half = 6;
    wbuf[0] = 8'h3C;
    run_frame(8'h05, 1);
    chk("single_wr_mem05", 32'(smem[5]), 32'h3C);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    run_frame(8'h7F, 3);
    chk("wrap_mem7f", 32'(smem[127]), 32'h11);
    chk("wrap_mem00", 32'(smem[0]), 32'h22);
    chk("wrap_mem01", 32'(smem[1]), 32'h33);

    run_frame(8'h90, 2);
    chk("rd_byte0", 32'(rxb[0]), 32'h00);
    chk("rd_byte1", 32'(rxb[1]), 32'hEF);
    chk("rd_byte2", 32'(rxb[2]), 32'hEE);

    // abort after 5 bits of a data byte
    cs_low();
    c = 8'h05;
    for (int j = 7; j >= 0; j--) spi_bit(c[j], m);
    for (int j = 0; j < 5; j++) spi_bit(1'($urandom), m);
    spi_cs = 1'b1;
    repeat (4) @(posedge clk_48mhz);
    #1;
    chk("abort_oe", 32'(spi_miso_oe), 32'd0);
    chk("abort_miso", 32'(spi_miso), 32'd0);
    repeat (8) @(posedge clk_48mhz);
    chk("abort_mem05", 32'(smem[5]), 32'h3C);

    // reset in the middle of a frame
    cs_low();
    c = 8'h01;
    for (int j = 7; j >= 5; j--) spi_bit(c[j], m);
    reset = 1'b1;
    #40;
    reset = 1'b0;
    model_reset();
    for (int j = 4; j >= 0; j--) begin
      spi_bit(c[j], m);
      chk("hold_miso", 32'(m), 32'd0);
      chk("hold_oe", 32'(spi_miso_oe), 32'd0);
    end
    c = 8'h5A;
    for (int j = 7; j >= 0; j--) begin
      spi_bit(c[j], m);
      chk("hold_miso", 32'(m), 32'd0);
      chk("hold_oe", 32'(spi_miso_oe), 32'd0);
    end
    spi_cs = 1'b1;
    repeat (10) @(posedge clk_48mhz);
    wbuf[0] = 8'hAA;
    run_frame(8'h01, 1);
    chk("post_reset_mem01", 32'(smem[1]), 32'hAA);

    // full sweep at minimum SCK high/low time
    half = 6;
    for (int i = 0; i < 128; i++) wbuf[i] = 8'($urandom);
    run_frame(8'h00, 128);
    run_frame(8'h80, 128);

    repeat (20) begin
      half = $urandom_range(6, 9);
      n = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      c = 8'($urandom);
      run_frame(c, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
